bus_arbiter: RTL and testbench

- 2-master to 1-port arbiter placed in front of `bus` master port, so CPU and a second master (DMA/keyboard engine) share the bus and the mem_controller slaves.
- Grants one master at a time using round-robin priority.
- Forwards the granted master's hello/ack transaction and releases the grant after ack, abort or timeout.
- Timeout watchdog returns an error ack when a slave never answers.

---
 rtl/bus_arbiter_pkg.sv | 14 +
 rtl/bus_arbiter_rr_pick.sv | 16 +
 rtl/bus_arbiter.sv | 116 +++++++++++
 tb/tb_bus_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and widths for the 2-master bus arbiter.
package bus_arbiter_pkg;

  localparam int WORDSIZE = 16;
  localparam int ADDRSIZE = 16;

  // Arbiter FSM encodings.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_BUSY    = 2'b01,
    ARB_RELEASE = 2'b10
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin pick: turns a request vector and the last-served index into a
// one-hot grant. When both request, the master that was not served last wins.
module arb_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  // A single requester is already one-hot; contention resolves against last.
  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) o_gnt = i_last ? 2'b01 : 2'b10;
    else                o_gnt = i_req;
  end

endmodule

// File: rtl/bus_arbiter.sv
// 2-to-1 bus arbiter: round-robin grant, forwards the granted master's
// hello/ack transaction, one release cycle between transactions, and a
// watchdog that returns an error ack when a slave never answers.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                arb_clk_i,
  input  logic                arb_rst_i,
  input  logic [WORDSIZE-1:0] m0_data_i,
  input  logic [ADDRSIZE-1:0] m0_addr_i,
  input  logic                m0_we_i,
  input  logic                m0_hello_i,
  output logic [WORDSIZE-1:0] m0_data_o,
  output logic                m0_ack_o,
  input  logic [WORDSIZE-1:0] m1_data_i,
  input  logic [ADDRSIZE-1:0] m1_addr_i,
  input  logic                m1_we_i,
  input  logic                m1_hello_i,
  output logic [WORDSIZE-1:0] m1_data_o,
  output logic                m1_ack_o,
  output logic [WORDSIZE-1:0] b_data_o,
  output logic [ADDRSIZE-1:0] b_addr_o,
  output logic                b_we_o,
  output logic                b_hello_o,
  input  logic [WORDSIZE-1:0] b_data_i,
  input  logic                b_ack_i,
  output logic [1:0]          arb_gnt_o,
  output logic                arb_err_o
);

  arb_state_e         r_state;
  logic [1:0]         r_gnt;
  logic               r_last;
  logic [CNT_W-1:0]   r_cnt;

  logic [1:0]          w_pick;
  logic                w_gidx;
  logic                w_act;
  logic                w_ghello;
  logic                w_timeout;
  logic                w_ack;
  logic [WORDSIZE-1:0] w_rdata;

  arb_rr_pick u_pick (
    .i_req  ({m1_hello_i, m0_hello_i}),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  // Outputs are gated by reset so nothing leaks while reset is held mid-BUSY.
  assign w_gidx    = r_gnt[1];
  assign w_act     = (r_state == ARB_BUSY) && !arb_rst_i;
  assign w_ghello  = w_gidx ? m1_hello_i : m0_hello_i;
  assign w_timeout = w_act && w_ghello && !b_ack_i && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_ack     = w_act && (b_ack_i || w_timeout);
  assign w_rdata   = w_timeout ? '0 : b_data_i;

  assign m0_ack_o  = w_ack && !w_gidx;
  assign m1_ack_o  = w_ack &&  w_gidx;
  assign m0_data_o = (w_act && !w_gidx) ? w_rdata : '0;
  assign m1_data_o = (w_act &&  w_gidx) ? w_rdata : '0;
  assign arb_err_o = w_timeout;
  assign arb_gnt_o = arb_rst_i ? 2'b00 : r_gnt;

  // Bus-side mux of the granted master; hello is withdrawn on a timeout.
  always_comb begin
    b_data_o  = '0;
    b_addr_o  = '0;
    b_we_o    = 1'b0;
    b_hello_o = 1'b0;
    if (w_act) begin
      b_data_o  = w_gidx ? m1_data_i : m0_data_i;
      b_addr_o  = w_gidx ? m1_addr_i : m0_addr_i;
      b_we_o    = w_gidx ? m1_we_i   : m0_we_i;
      b_hello_o = w_ghello && !w_timeout;
    end
  end

  // Arbitration FSM with timeout counter; ack beats abort beats timeout.
  always_ff @(posedge arb_clk_i) begin
    if (arb_rst_i) begin
      r_state <= ARB_IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_cnt <= '0;
          if (w_pick != 2'b00) begin
            r_gnt   <= w_pick;
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (b_ack_i || !w_ghello || w_timeout) begin
            r_last  <= w_gidx;
            r_state <= ARB_RELEASE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ARB_RELEASE: begin
          r_gnt   <= 2'b00;
          r_cnt   <= '0;
          r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: scenario tasks with a scoreboard of
// expected grants and read data.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic                arb_clk_i = 1'b0;
  logic                arb_rst_i;
  logic [WORDSIZE-1:0] m0_data_i, m1_data_i, b_data_i;
  logic [ADDRSIZE-1:0] m0_addr_i, m1_addr_i;
  logic                m0_we_i, m1_we_i, m0_hello_i, m1_hello_i, b_ack_i;
  logic [WORDSIZE-1:0] m0_data_o, m1_data_o, b_data_o;
  logic [ADDRSIZE-1:0] b_addr_o;
  logic                m0_ack_o, m1_ack_o, b_we_o, b_hello_o, arb_err_o;
  logic [1:0]          arb_gnt_o;

  int checks = 0;
  int errors = 0;
  logic [WORDSIZE-1:0] exp_q[$];
  logic [1:0]          gnt_q[$];
  logic [70:0]         w_all;

  assign w_all = {b_data_o, b_addr_o, b_we_o, b_hello_o, m0_data_o, m0_ack_o,
                  m1_data_o, m1_ack_o, arb_gnt_o, arb_err_o};

  always #5 arb_clk_i = ~arb_clk_i;

  bus_arbiter #(.TIMEOUT(16), .CNT_W(8)) dut (
    .arb_clk_i (arb_clk_i), .arb_rst_i (arb_rst_i),
    .m0_data_i (m0_data_i), .m0_addr_i (m0_addr_i), .m0_we_i (m0_we_i),
    .m0_hello_i(m0_hello_i), .m0_data_o (m0_data_o), .m0_ack_o (m0_ack_o),
    .m1_data_i (m1_data_i), .m1_addr_i (m1_addr_i), .m1_we_i (m1_we_i),
    .m1_hello_i(m1_hello_i), .m1_data_o (m1_data_o), .m1_ack_o (m1_ack_o),
    .b_data_o  (b_data_o),  .b_addr_o  (b_addr_o),  .b_we_o   (b_we_o),
    .b_hello_o (b_hello_o), .b_data_i  (b_data_i),  .b_ack_i  (b_ack_i),
    .arb_gnt_o (arb_gnt_o), .arb_err_o (arb_err_o)
  );

  // Inputs change just after the rising edge; outputs are sampled mid-cycle.
  task automatic to_drive();
    @(posedge arb_clk_i); #1;
  endtask

  task automatic to_sample();
    @(negedge arb_clk_i);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      to_sample();
      checks++;
      if (w_all !== '0) begin errors++; $display("FAIL reset_outs: got %h want 0", w_all); end
    end
    to_drive(); arb_rst_i = 1'b0;
    to_sample();
    checks++;
    if (arb_gnt_o !== 2'b00 || b_hello_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle: gnt %b hello %b want 00 0", arb_gnt_o, b_hello_o);
    end
    to_drive();
    to_sample();
    checks++;
    if (arb_gnt_o !== 2'b01 || b_hello_o !== 1'b1 || b_addr_o !== 16'h0011) begin
      errors++; $display("FAIL reset_first_gnt: gnt %b hello %b addr %h want 01 1 0011",
                         arb_gnt_o, b_hello_o, b_addr_o);
    end
    to_drive(); m0_hello_i = 1'b0; m1_hello_i = 1'b0;
    to_drive(); to_drive();
  endtask

  task automatic test_m1_write();
    int n;
    logic [WORDSIZE-1:0] e;
    to_drive();
    m1_hello_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 16'h0005; m1_data_i = 16'h1234;
    n = 0;
    to_sample();
    while (b_hello_o !== 1'b1 && n < 10) begin to_drive(); to_sample(); n++; end
    checks++;
    if (n !== 1) begin errors++; $display("FAIL m1_latency: got %0d want 1", n); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        to_drive();
        if (k == 2) begin b_ack_i = 1'b1; b_data_i = 16'h5A5A; exp_q.push_back(16'h5A5A); end
        to_sample();
      end
      checks++;
      if ({b_we_o, b_addr_o, b_data_o, arb_gnt_o} !== {1'b1, 16'h0005, 16'h1234, 2'b10}) begin
        errors++; $display("FAIL m1_bus k=%0d: we %b addr %h data %h gnt %b want 1 0005 1234 10",
                           k, b_we_o, b_addr_o, b_data_o, arb_gnt_o);
      end
      if (k < 2) begin
        checks++;
        if (m1_ack_o !== 1'b0 || m0_ack_o !== 1'b0) begin
          errors++; $display("FAIL m1_early_ack k=%0d: m0 %b m1 %b want 0 0", k, m0_ack_o, m1_ack_o);
        end
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (m1_ack_o !== 1'b1 || m1_data_o !== e || m0_ack_o !== 1'b0 || m0_data_o !== '0) begin
      errors++; $display("FAIL m1_ack: m1 %b/%h m0 %b/%h want 1/%h 0/0000",
                         m1_ack_o, m1_data_o, m0_ack_o, m0_data_o, e);
    end
    to_drive(); b_ack_i = 1'b0; b_data_i = '0; m1_hello_i = 1'b0; m1_we_i = 1'b0;
    to_sample();
    checks++;
    if (b_hello_o !== 1'b0 || m1_ack_o !== 1'b0) begin
      errors++; $display("FAIL m1_release: hello %b ack %b want 0 0", b_hello_o, m1_ack_o);
    end
    to_drive(); to_sample();
    checks++;
    if (arb_gnt_o !== 2'b00 || b_hello_o !== 1'b0) begin
      errors++; $display("FAIL m1_idle: gnt %b hello %b want 00 0", arb_gnt_o, b_hello_o);
    end
  endtask

  task automatic test_back_to_back();
    int seen;
    logic [1:0] g;
    gnt_q.push_back(2'b01); gnt_q.push_back(2'b10);
    gnt_q.push_back(2'b01); gnt_q.push_back(2'b10);
    to_drive(); m0_hello_i = 1'b1; m1_hello_i = 1'b1; m1_we_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 30 && seen < 4; c++) begin
      to_drive();
      if (b_hello_o === 1'b1) begin
        b_ack_i = 1'b1; b_data_i = arb_gnt_o[0] ? 16'hBEEF : 16'hCAFE;
      end else begin
        b_ack_i = 1'b0; b_data_i = '0;
      end
      to_sample();
      checks++;
      if (b_hello_o === 1'b1) begin
        g = gnt_q.pop_front();
        seen++;
        if (arb_gnt_o !== g || m0_ack_o !== g[0] || m1_ack_o !== g[1] ||
            m0_data_o !== (g[0] ? 16'hBEEF : 16'h0000) ||
            m1_data_o !== (g[1] ? 16'hCAFE : 16'h0000)) begin
          errors++; $display("FAIL rr_txn%0d: gnt %b ack %b%b data %h/%h want gnt %b",
                             seen, arb_gnt_o, m1_ack_o, m0_ack_o, m0_data_o, m1_data_o, g);
        end
      end else if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || m0_data_o !== '0) begin
        errors++; $display("FAIL rr_gap: acks %b%b m0_data %h want 00 0000",
                           m1_ack_o, m0_ack_o, m0_data_o);
      end
    end
    checks++;
    if (seen !== 4) begin errors++; $display("FAIL rr_count: got %0d want 4", seen); end
    to_drive(); m0_hello_i = 1'b0; m1_hello_i = 1'b0; b_ack_i = 1'b0; b_data_i = '0;
    to_drive(); to_drive();
  endtask

  task automatic test_timeout();
    logic [WORDSIZE-1:0] e;
    b_data_i = 16'hFFFF;
    exp_q.push_back(16'h0000);
    m0_addr_i = 16'h0040; m0_hello_i = 1'b1;
    to_drive();
    for (int n = 1; n <= 16; n++) begin
      to_sample();
      checks++;
      if (n < 16) begin
        if ({m0_ack_o, arb_err_o, b_hello_o} !== 3'b001 || m0_data_o !== 16'hFFFF) begin
          errors++; $display("FAIL to_wait n=%0d: ack %b err %b hello %b data %h want 0 0 1 ffff",
                             n, m0_ack_o, arb_err_o, b_hello_o, m0_data_o);
        end
        to_drive();
      end else begin
        e = exp_q.pop_front();
        if ({m0_ack_o, arb_err_o, b_hello_o, m1_ack_o} !== 4'b1100 || m0_data_o !== e) begin
          errors++; $display("FAIL to_fire: ack %b err %b hello %b m1ack %b data %h want 1 1 0 0 %h",
                             m0_ack_o, arb_err_o, b_hello_o, m1_ack_o, m0_data_o, e);
        end
      end
    end
    to_drive(); m0_hello_i = 1'b0; b_data_i = '0;
    to_sample();
    checks++;
    if (arb_err_o !== 1'b0 || m0_ack_o !== 1'b0) begin
      errors++; $display("FAIL to_pulse_len: err %b ack %b want 0 0", arb_err_o, m0_ack_o);
    end
    to_drive(); m1_hello_i = 1'b1;
    to_drive(); b_ack_i = 1'b1; b_data_i = 16'h7777;
    to_sample();
    checks++;
    if (m1_ack_o !== 1'b1 || m1_data_o !== 16'h7777 || arb_err_o !== 1'b0) begin
      errors++; $display("FAIL to_next_txn: ack %b data %h err %b want 1 7777 0",
                         m1_ack_o, m1_data_o, arb_err_o);
    end
    to_drive(); b_ack_i = 1'b0; b_data_i = '0; m1_hello_i = 1'b0;
    to_drive();
  endtask

  task automatic test_abort();
    gnt_q.push_back(2'b10);
    m0_hello_i = 1'b1; m1_hello_i = 1'b1;
    to_drive(); to_sample();
    checks++;
    if (arb_gnt_o !== 2'b01) begin errors++; $display("FAIL ab_first: gnt %b want 01", arb_gnt_o); end
    to_drive(); to_sample();
    to_drive(); m0_hello_i = 1'b0;
    to_sample();
    checks++;
    if ({m0_ack_o, m1_ack_o, arb_err_o, b_hello_o} !== 4'b0000) begin
      errors++; $display("FAIL ab_drop: ack %b%b err %b hello %b want 0000",
                         m1_ack_o, m0_ack_o, arb_err_o, b_hello_o);
    end
    for (int i = 1; i <= 3; i++) begin
      to_drive(); to_sample();
      checks++;
      if (i < 3) begin
        if ({m0_ack_o, m1_ack_o, arb_err_o, b_hello_o} !== 4'b0000) begin
          errors++; $display("FAIL ab_gap%0d: ack %b%b err %b hello %b want 0000",
                             i, m1_ack_o, m0_ack_o, arb_err_o, b_hello_o);
        end
      end else begin
        if (arb_gnt_o !== gnt_q.pop_front() || b_hello_o !== 1'b1 || b_addr_o !== 16'h0022) begin
          errors++; $display("FAIL ab_next: gnt %b hello %b addr %h want 10 1 0022",
                             arb_gnt_o, b_hello_o, b_addr_o);
        end
      end
    end
    to_drive(); b_ack_i = 1'b1;
    to_sample();
    checks++;
    if (m1_ack_o !== 1'b1) begin errors++; $display("FAIL ab_m1_ack: got %b want 1", m1_ack_o); end
    to_drive(); b_ack_i = 1'b0; m1_hello_i = 1'b0;
    to_drive();
  endtask

  task automatic test_reset_mid();
    m0_hello_i = 1'b1;
    to_drive(); b_ack_i = 1'b1;
    to_sample();
    checks++;
    if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL rm_m0_ack: got %b want 1", m0_ack_o); end
    to_drive(); b_ack_i = 1'b0;
    to_drive(); to_drive();
    to_sample();
    checks++;
    if (arb_gnt_o !== 2'b01) begin errors++; $display("FAIL rm_regrant: gnt %b want 01", arb_gnt_o); end
    to_drive(); arb_rst_i = 1'b1; b_ack_i = 1'b1; m1_hello_i = 1'b1;
    to_sample();
    checks++;
    if (w_all !== '0) begin errors++; $display("FAIL rm_during: got %h want 0", w_all); end
    to_drive(); arb_rst_i = 1'b0;
    to_sample();
    checks++;
    if (arb_gnt_o !== 2'b00 || b_hello_o !== 1'b0 || m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
      errors++; $display("FAIL rm_after: gnt %b hello %b ack %b%b want 00 0 00",
                         arb_gnt_o, b_hello_o, m1_ack_o, m0_ack_o);
    end
    to_drive(); b_ack_i = 1'b0;
    to_sample();
    checks++;
    if (arb_gnt_o !== 2'b01) begin errors++; $display("FAIL rm_m0_first: gnt %b want 01", arb_gnt_o); end
  endtask

  initial begin
    arb_rst_i = 1'b1;
    m0_data_i = 16'hA0A0; m0_addr_i = 16'h0011; m0_we_i = 1'b0; m0_hello_i = 1'b1;
    m1_data_i = 16'hB1B1; m1_addr_i = 16'h0022; m1_we_i = 1'b0; m1_hello_i = 1'b1;
    b_data_i = '0; b_ack_i = 1'b0;
    test_reset();
    test_m1_write();
    m1_addr_i = 16'h0022;
    test_back_to_back();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
